// File: rtl/map_ram_loader.sv
// rtl/map_ram_loader.sv - expands an RLE palette-index byte stream into row-major background map RAM writes
module map_ram_loader #(
  parameter int DEPTH      = 76800,
  parameter int ADDR_W     = 17,
  parameter int NUM_COLORS = 23
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [5:0]        ram_data,
  output logic              busy,
  output logic              done,
  output logic              error
);

  typedef enum logic [1:0] {IDLE, FETCH, WRITE, DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH - 1);
  localparam logic [5:0]        COLOR_LIM  = 6'(NUM_COLORS);

  state_t            state, state_nxt;
  logic [2:0]        cnt, cnt_nxt;
  logic              we_nxt, busy_nxt, done_nxt, error_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [5:0]        data_nxt;
  logic              idx_ok;

  assign idx_ok = ({1'b0, in_data[4:0]} < COLOR_LIM);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= IDLE;
      cnt      <= 3'd0;
      ram_we   <= 1'b0;
      ram_addr <= '0;
      ram_data <= 6'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      ram_we   <= we_nxt;
      ram_addr <= addr_nxt;
      ram_data <= data_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
      error    <= error_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    we_nxt    = ram_we;
    addr_nxt  = ram_addr;
    data_nxt  = ram_data;
    busy_nxt  = busy;
    done_nxt  = done;
    error_nxt = error;
    in_ready  = 1'b0;
    case (state)
      IDLE: begin
        we_nxt = 1'b0;
        if (start) begin
          addr_nxt  = '0;
          done_nxt  = 1'b0;
          error_nxt = 1'b0;
          busy_nxt  = 1'b1;
          state_nxt = FETCH;
        end
      end
      FETCH: begin
        in_ready = 1'b1;
        we_nxt   = 1'b0;
        if (in_valid) begin
          cnt_nxt   = in_data[7:5];
          we_nxt    = 1'b1;
          state_nxt = WRITE;
          // out-of-range indices still occupy their slots, written as color 0
          if (idx_ok) begin
            data_nxt = {1'b0, in_data[4:0]};
          end else begin
            data_nxt  = 6'd0;
            error_nxt = 1'b1;
          end
        end
      end
      WRITE: begin
        if (ram_addr == LAST_ADDR) begin
          we_nxt    = 1'b0;
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
          state_nxt = DONE;
          if (cnt != 3'd0) error_nxt = 1'b1;
        end else if (cnt == 3'd0) begin
          addr_nxt  = ram_addr + ADDR_W'(1);
          we_nxt    = 1'b0;
          state_nxt = FETCH;
        end else begin
          addr_nxt = ram_addr + ADDR_W'(1);
          cnt_nxt  = cnt - 3'd1;
        end
      end
      DONE: begin
        we_nxt    = 1'b0;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_map_ram_loader.sv
// tb/tb_map_ram_loader.sv - directed checks of map_ram_loader with a 10-entry map
module tb_map_ram_loader;
  localparam int DEPTH  = 10;
  localparam int ADDR_W = 17;

  logic              Clk = 1'b0;
  logic              Reset, start, in_valid;
  logic [7:0]        in_data;
  logic              in_ready, ram_we, busy, done, error;
  logic [ADDR_W-1:0] ram_addr;
  logic [5:0]        ram_data;

  int vectors = 0, miscompares = 0, cyc = 0;
  int wa[$], wd[$], wt[$];
  int mem[16];

  always #5 Clk = ~Clk;

  map_ram_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .NUM_COLORS(23)) dut (
    .Clk(Clk), .Reset(Reset), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .ram_we(ram_we), .ram_addr(ram_addr), .ram_data(ram_data),
    .busy(busy), .done(done), .error(error)
  );

  always @(posedge Clk) cyc <= cyc + 1;

  always @(negedge Clk) begin
    if (ram_we) begin
      wa.push_back(int'(ram_addr));
      wd.push_back(int'(ram_data));
      wt.push_back(cyc);
      if (ram_addr < 16) mem[ram_addr[3:0]] = int'(ram_data);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic clear_log();
    wa.delete(); wd.delete(); wt.delete();
    foreach (mem[i]) mem[i] = -1;
  endtask

  task automatic do_reset();
    Reset = 1'b1; tick(); tick(); Reset = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic stream(input logic [7:0] toks[4], input int n, input int period);
    int k = 0;
    int c = 0;
    while (k < n && c < 200) begin
      in_data  = toks[k];
      in_valid = (c % period == 0);
      if (in_valid && in_ready) k++;
      tick();
      c++;
    end
    in_valid = 1'b0;
    if (k < n) check("stream_timeout", k, n);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 100) begin tick(); n++; end
    check("done_reached", done, 1);
    tick();
  endtask

  task automatic check_image(input string tag, input int exp[10]);
    for (int i = 0; i < 10; i++) check($sformatf("%s[%0d]", tag, i), mem[i], exp[i]);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    Reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    clear_log();
    tick(); tick();
    check("rst_in_ready", in_ready, 0);
    check("rst_ram_we", ram_we, 0);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_ram_data", ram_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    Reset = 1'b0;

    // run of 8 with a start pulse arriving mid-run
    start = 1'b1; in_valid = 1'b1; in_data = 8'hE3;
    tick();
    start = 1'b0;
    check("t1_fetch_ready", in_ready, 1);
    check("t1_fetch_busy", busy, 1);
    check("t1_fetch_we", ram_we, 0);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("t1_we[%0d]", i), ram_we, 1);
      check($sformatf("t1_addr[%0d]", i), ram_addr, i);
      check($sformatf("t1_data[%0d]", i), ram_data, 3);
      check($sformatf("t1_ready[%0d]", i), in_ready, 0);
      start = (i == 3);
      tick();
    end
    start = 1'b0;
    check("t1_after_we", ram_we, 0);
    check("t1_after_addr", ram_addr, 8);
    check("t1_after_ready", in_ready, 1);
    check("t1_after_busy", busy, 1);
    check("t1_after_error", error, 0);
    check("t1_nwrites", wa.size(), 8);
    do_reset();

    // back-to-back tokens with a FETCH bubble between them
    clear_log();
    pulse_start();
    stream('{8'h05, 8'h27, 8'h00, 8'h00}, 2, 1);
    repeat (4) tick();
    check("t2_nwrites", wa.size(), 3);
    if (wa.size() == 3) begin
      check("t2_a0", wa[0], 0); check("t2_d0", wd[0], 5);
      check("t2_a1", wa[1], 1); check("t2_d1", wd[1], 7);
      check("t2_a2", wa[2], 2); check("t2_d2", wd[2], 7);
      check("t2_bubble", wt[1] - wt[0], 2);
      check("t2_run", wt[2] - wt[1], 1);
    end
    check("t2_busy", busy, 1);
    check("t2_done", done, 0);
    do_reset();

    // invalid index: written as 0, sticky error, cleared by next load
    clear_log();
    pulse_start();
    stream('{8'h1F, 8'h00, 8'h00, 8'h00}, 1, 1);
    tick(); tick();
    check("t3_bad_data", mem[0], 0);
    check("t3_bad_error", error, 1);
    stream('{8'hE1, 8'h01, 8'h00, 8'h00}, 2, 1);
    wait_done();
    check("t3_error_sticky", error, 1);
    check("t3_busy", busy, 0);
    check_image("t3_img", '{0, 1, 1, 1, 1, 1, 1, 1, 1, 1});
    clear_log();
    pulse_start();
    check("t3_restart_error", error, 0);
    check("t3_restart_done", done, 0);
    check("t3_restart_busy", busy, 1);
    stream('{8'hE1, 8'h22, 8'h00, 8'h00}, 2, 1);
    wait_done();
    check("t3_clean_error", error, 0);
    check_image("t3_clean_img", '{1, 1, 1, 1, 1, 1, 1, 1, 2, 2});

    // full load with the second run truncated at the last address
    clear_log();
    pulse_start();
    stream('{8'hE1, 8'hE2, 8'h00, 8'h00}, 2, 1);
    wait_done();
    check("t4_error", error, 1);
    check("t4_done", done, 1);
    check("t4_busy", busy, 0);
    check("t4_we", ram_we, 0);
    check("t4_nwrites", wa.size(), 10);
    check_image("t4_img", '{1, 1, 1, 1, 1, 1, 1, 1, 2, 2});
    in_valid = 1'b1; in_data = 8'h05;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("t4_post_ready[%0d]", i), in_ready, 0);
      check($sformatf("t4_post_done[%0d]", i), done, 1);
      tick();
    end
    in_valid = 1'b0;
    check("t4_post_nwrites", wa.size(), 10);

    // Reset asserted while writing address 4
    clear_log();
    pulse_start();
    check("t5_done_cleared", done, 0);
    in_valid = 1'b1; in_data = 8'hE3;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 10 && !(ram_we && ram_addr == 4); i++) tick();
    check("t5_at_addr4", ram_addr, 4);
    Reset = 1'b1; tick(); Reset = 1'b0;
    check("t5_we", ram_we, 0);
    check("t5_addr", ram_addr, 0);
    check("t5_busy", busy, 0);
    check("t5_done", done, 0);
    check("t5_ready", in_ready, 0);

    // same stream unthrottled, then with in_valid 1 on / 3 off
    clear_log();
    pulse_start();
    stream('{8'h43, 8'h05, 8'h27, 8'h64}, 4, 1);
    wait_done();
    check_image("t6_fast_img", '{3, 3, 3, 5, 7, 7, 4, 4, 4, 4});
    check("t6_fast_error", error, 0);
    clear_log();
    pulse_start();
    stream('{8'h43, 8'h05, 8'h27, 8'h64}, 4, 4);
    wait_done();
    check_image("t6_slow_img", '{3, 3, 3, 5, 7, 7, 4, 4, 4, 4});
    check("t6_slow_nwrites", wa.size(), 10);
    if (wt.size() == 10) check("t6_slow_paused", (wt[9] - wt[0]) > 12, 1);
    check("t6_slow_error", error, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
